ept_active_fifo: RTL and testbench

Parametrised active endpoint sitting between the 32-bit UC_IN / 30-bit UC_OUT endpoint bus and user logic. It generalises the single-byte active transfer endpoint with three additions: an independent RX FIFO (host→device) and TX FIFO (device→host), a configurable endpoint address and depth, and valid/ready user interfaces. Block transfers in either direction run without per-byte user involvement.

---
 rtl/ept_pkg.sv | 13 +
 rtl/ept_sync_fifo.sv | 39 +++
 rtl/ept_active_fifo.sv | 157 +++++++++++++++
 tb/tb_ept_active_fifo.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ept_pkg.sv
// ept_pkg: endpoint bus bit positions and FSM state encodings for ept_active_fifo.
package ept_pkg;
  localparam int UC_BUSY    = 31;
  localparam int UC_READY   = 30;
  localparam int UC_ADDR_HI = 29;
  localparam int UC_ADDR_LO = 27;
  localparam int UC_BLK     = 26;
  localparam int UC_LEN_HI  = 25;
  localparam int UC_LEN_LO  = 18;
  localparam int UC_TRIG    = 8;
  typedef enum logic [1:0] {R_IDLE, R_BYTE, R_WAIT_LOW} rx_st_t;
  typedef enum logic [2:0] {T_IDLE, T_CMD, T_BYTE, T_WAIT_LOW, T_END} tx_st_t;
endpackage

// File: rtl/ept_sync_fifo.sv
// ept_sync_fifo: first-word-fall-through synchronous FIFO with occupancy output.
module ept_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
) (
  input  logic                     uc_clk,
  input  logic                     uc_reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [AW:0]      r_wp, r_rp;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push, w_pop;
  assign o_level = r_wp - r_rp;
  assign o_full  = o_level == FULL;
  assign o_dout  = r_mem[r_rp[AW-1:0]];
  assign w_pop   = i_pop & (o_level != '0);
  // a full FIFO still takes a push when the same cycle frees a slot
  assign w_push  = i_push & (~o_full | w_pop);
  always_ff @(posedge uc_clk or negedge uc_reset) begin
    if (!uc_reset) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + ONE;
      if (w_pop) r_rp <= r_rp + ONE;
    end
  end
  always_ff @(posedge uc_clk) begin
    if (w_push) r_mem[r_wp[AW-1:0]] <= i_din;
  end
endmodule

// File: rtl/ept_active_fifo.sv
// ept_active_fifo: active endpoint with RX/TX FIFOs between the uc_in/uc_out bus and user logic.
// Define EPT_ERR_CNT_EN to add saturating rx_drop_cnt / tx_reject_cnt outputs.
module ept_active_fifo
  import ept_pkg::*;
#(
  parameter logic [2:0] ADDR     = 3'd0,
  parameter int         RX_DEPTH = 256,
  parameter int         TX_DEPTH = 256,
  parameter int         CMD_HOLD = 2
) (
  input  logic                        uc_clk,
  input  logic                        uc_reset,
  input  logic [31:0]                 uc_in,
  output logic [29:0]                 uc_out,
  output logic                        transfer_busy,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(RX_DEPTH):0]   rx_level,
  output logic                        rx_overflow,
  output logic                        rx_block_done,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [$clog2(TX_DEPTH):0]   tx_level,
  input  logic                        tx_start,
  input  logic [7:0]                  tx_len,
  output logic                        tx_reject,
  output logic                        tx_busy,
`ifdef EPT_ERR_CNT_EN
  output logic                        tx_done,
  output logic [7:0]                  rx_drop_cnt,
  output logic [7:0]                  tx_reject_cnt
`else
  output logic                        tx_done
`endif
);
  localparam logic [3:0] HOLD_LAST = 4'(CMD_HOLD - 1);
  rx_st_t      r_rx_st;
  tx_st_t      r_tx_st, w_tx_nxt;
  logic [7:0]  r_rx_len, r_rx_cnt, r_tx_cnt, w_tx_head;
  logic [3:0]  r_hold;
  logic [29:0] r_uc_out, w_uc_nxt;
  logic        r_rx_done, r_rx_ovf, r_tx_done, r_tx_reject;
  logic        w_rx_full, w_tx_full, w_rx_push, w_rx_pop, w_rx_drop, w_hdr_hit, w_tx_acc, w_tx_pop;
  logic        w_unused;
  assign w_unused      = ^uc_in[17:8];
  assign transfer_busy = uc_in[UC_BUSY];
  assign uc_out        = r_uc_out;
  assign rx_valid      = rx_level != '0;
  assign rx_overflow   = r_rx_ovf;
  assign rx_block_done = r_rx_done;
  assign tx_ready      = ~w_tx_full;
  assign tx_reject     = r_tx_reject;
  assign tx_busy       = r_tx_st != T_IDLE;
  assign tx_done       = r_tx_done;
  assign w_hdr_hit     = (uc_in[UC_ADDR_HI:UC_ADDR_LO] == ADDR) & uc_in[UC_BLK];
  assign w_rx_push     = (r_rx_st == R_BYTE) & uc_in[UC_READY];
  assign w_rx_pop      = rx_valid & rx_ready;
  assign w_rx_drop     = w_rx_push & w_rx_full & ~w_rx_pop;
  assign w_tx_acc      = tx_start & (tx_len != 8'd0) & (32'(tx_level) >= 32'(tx_len));
  ept_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .uc_clk(uc_clk), .uc_reset(uc_reset), .i_push(w_rx_push), .i_pop(rx_ready),
    .i_din(uc_in[7:0]), .o_dout(rx_data), .o_full(w_rx_full), .o_level(rx_level)
  );
  ept_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .uc_clk(uc_clk), .uc_reset(uc_reset), .i_push(tx_valid), .i_pop(w_tx_pop),
    .i_din(tx_data), .o_dout(w_tx_head), .o_full(w_tx_full), .o_level(tx_level)
  );
  always_ff @(posedge uc_clk or negedge uc_reset) begin
    if (!uc_reset) begin
      r_rx_st   <= R_IDLE;
      r_rx_len  <= '0;
      r_rx_cnt  <= '0;
      r_rx_done <= 1'b0;
      r_rx_ovf  <= 1'b0;
    end else begin
      r_rx_done <= 1'b0;
      if (w_rx_drop) r_rx_ovf <= 1'b1;
      case (r_rx_st)
        R_IDLE: if (w_hdr_hit) begin
          r_rx_len  <= uc_in[UC_LEN_HI:UC_LEN_LO];
          r_rx_cnt  <= '0;
          r_rx_done <= uc_in[UC_LEN_HI:UC_LEN_LO] == 8'd0;
          r_rx_st   <= (uc_in[UC_LEN_HI:UC_LEN_LO] == 8'd0) ? R_IDLE : R_BYTE;
        end
        R_BYTE: if (uc_in[UC_READY]) begin
          r_rx_cnt <= r_rx_cnt + 8'd1;
          r_rx_st  <= R_WAIT_LOW;
        end
        R_WAIT_LOW: if (!uc_in[UC_READY]) begin
          r_rx_done <= r_rx_cnt == r_rx_len;
          r_rx_st   <= (r_rx_cnt == r_rx_len) ? R_IDLE : R_BYTE;
        end
        default: r_rx_st <= R_IDLE;
      endcase
    end
  end
  // uc_out is computed one state ahead so it stays a plain register
  always_comb begin
    w_tx_nxt = r_tx_st;
    w_uc_nxt = r_uc_out;
    w_tx_pop = 1'b0;
    case (r_tx_st)
      T_IDLE: if (w_tx_acc) begin
        w_tx_nxt = T_CMD;
        w_uc_nxt = {ADDR, 1'b1, tx_len, 18'd0};
      end
      T_CMD: if (r_hold == HOLD_LAST) begin
        w_tx_nxt = T_BYTE;
        w_uc_nxt = {r_uc_out[29:UC_TRIG+1], 1'b1, w_tx_head};
      end
      T_BYTE: if (uc_in[UC_READY]) begin
        w_tx_pop = 1'b1;
        w_tx_nxt = T_WAIT_LOW;
      end
      T_WAIT_LOW: if (!uc_in[UC_READY]) begin
        w_tx_nxt = (r_tx_cnt == 8'd0) ? T_END : T_BYTE;
        w_uc_nxt = (r_tx_cnt == 8'd0) ? '0 : {r_uc_out[29:8], w_tx_head};
      end
      T_END: w_tx_nxt = T_IDLE;
      default: w_tx_nxt = T_IDLE;
    endcase
  end
  always_ff @(posedge uc_clk or negedge uc_reset) begin
    if (!uc_reset) begin
      r_tx_st     <= T_IDLE;
      r_uc_out    <= '0;
      r_tx_cnt    <= '0;
      r_hold      <= '0;
      r_tx_done   <= 1'b0;
      r_tx_reject <= 1'b0;
    end else begin
      r_tx_st     <= w_tx_nxt;
      r_uc_out    <= w_uc_nxt;
      r_tx_done   <= w_tx_nxt == T_END;
      r_tx_reject <= (r_tx_st == T_IDLE) & tx_start & ~w_tx_acc;
      r_hold      <= (r_tx_st == T_CMD) ? r_hold + 4'd1 : 4'd0;
      if ((r_tx_st == T_IDLE) & w_tx_acc) r_tx_cnt <= tx_len;
      else if (w_tx_pop) r_tx_cnt <= r_tx_cnt - 8'd1;
    end
  end
`ifdef EPT_ERR_CNT_EN
  logic [7:0] r_rx_drop_cnt, r_tx_reject_cnt;
  assign rx_drop_cnt   = r_rx_drop_cnt;
  assign tx_reject_cnt = r_tx_reject_cnt;
  always_ff @(posedge uc_clk or negedge uc_reset) begin
    if (!uc_reset) begin
      r_rx_drop_cnt   <= '0;
      r_tx_reject_cnt <= '0;
    end else begin
      if (w_rx_drop && r_rx_drop_cnt != 8'hFF) r_rx_drop_cnt <= r_rx_drop_cnt + 8'd1;
      if (r_tx_reject && r_tx_reject_cnt != 8'hFF) r_tx_reject_cnt <= r_tx_reject_cnt + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ept_active_fifo.sv
// tb_ept_active_fifo: directed bench with a queue-based model of both FIFOs checked every cycle.
module tb_ept_active_fifo;
  import ept_pkg::*;
  localparam logic [2:0] ADDR = 3'd5;
  localparam int RXD = 4, TXD = 8, HOLD = 2;
  logic        uc_clk = 1'b0, uc_reset = 1'b1;
  logic [31:0] uc_in = '0;
  logic [29:0] uc_out;
  logic        transfer_busy, rx_valid, rx_ready = 1'b0, rx_overflow, rx_block_done;
  logic [7:0]  rx_data, tx_data = '0, tx_len = '0;
  logic [2:0]  rx_level;
  logic [3:0]  tx_level;
  logic        tx_valid = 1'b0, tx_ready, tx_start = 1'b0, tx_reject, tx_busy, tx_done;
`ifdef EPT_ERR_CNT_EN
  logic [7:0]  rx_drop_cnt, tx_reject_cnt;
`endif
  int checks = 0, failures = 0, rx_done_n = 0, tx_done_n = 0;
  bit m_rx_push = 1'b0, m_tx_pop = 1'b0, m_ovf = 1'b0, rp, tp;
  logic [7:0] rxq[$], txq[$];
  logic [29:0] hdr;

  ept_active_fifo #(.ADDR(ADDR), .RX_DEPTH(RXD), .TX_DEPTH(TXD), .CMD_HOLD(HOLD)) dut (
    .uc_clk(uc_clk), .uc_reset(uc_reset), .uc_in(uc_in), .uc_out(uc_out),
    .transfer_busy(transfer_busy), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_level(rx_level), .rx_overflow(rx_overflow), .rx_block_done(rx_block_done),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_level(tx_level),
    .tx_start(tx_start), .tx_len(tx_len), .tx_reject(tx_reject), .tx_busy(tx_busy),
`ifdef EPT_ERR_CNT_EN
    .tx_done(tx_done), .rx_drop_cnt(rx_drop_cnt), .tx_reject_cnt(tx_reject_cnt)
`else
    .tx_done(tx_done)
`endif
  );

  always #5 uc_clk = ~uc_clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge uc_clk);
    #2;
  endtask

  // host bytes are base + i*stride; only blocks aimed at ADDR are expected to land in the RX FIFO
  task automatic send_block(input logic [2:0] a, input int len, input logic [7:0] base, input logic [7:0] stride);
    uc_in = {1'b1, 1'b0, a, 1'b1, 8'(len), 18'd0};
    step();
    uc_in[UC_BLK] = 1'b0;
    for (int i = 0; i < len; i++) begin
      uc_in[7:0] = base + 8'(i) * stride;
      uc_in[UC_READY] = 1'b1;
      m_rx_push = (a == ADDR);
      step();
      uc_in[UC_READY] = 1'b0;
      m_rx_push = 1'b0;
      step();
    end
    uc_in = '0;
  endtask

  always @(posedge uc_clk or negedge uc_reset) begin
    if (!uc_reset) begin
      rxq.delete();
      txq.delete();
      m_ovf = 1'b0;
    end else begin
      rp = rx_ready && rxq.size() > 0;
      tp = m_tx_pop && txq.size() > 0;
      if (m_rx_push && rxq.size() == RXD && !rp) m_ovf = 1'b1;
      else if (m_rx_push) rxq.push_back(uc_in[7:0]);
      if (rp) void'(rxq.pop_front());
      if (tx_valid && (txq.size() < TXD || tp)) txq.push_back(tx_data);
      if (tp) void'(txq.pop_front());
    end
  end

  always @(negedge uc_clk) begin
    chk("rx_level", rx_level, rxq.size());
    chk("rx_valid", rx_valid, rxq.size() != 0);
    if (rxq.size() != 0) chk("rx_data", rx_data, rxq[0]);
    chk("tx_level", tx_level, txq.size());
    chk("tx_ready", tx_ready, txq.size() < TXD);
    chk("rx_overflow", rx_overflow, m_ovf);
    chk("transfer_busy", transfer_busy, uc_in[UC_BUSY]);
    if (rx_block_done) rx_done_n++;
    if (tx_done) tx_done_n++;
  end

  initial begin
    #1 uc_reset = 1'b0;
    #1;
    chk("rst uc_out", uc_out, 0);
    chk("rst rx_valid", rx_valid, 0);
    chk("rst rx_level", rx_level, 0);
    chk("rst rx_overflow", rx_overflow, 0);
    chk("rst rx_block_done", rx_block_done, 0);
    chk("rst tx_ready", tx_ready, 1);
    chk("rst tx_level", tx_level, 0);
    chk("rst tx_reject", tx_reject, 0);
    chk("rst tx_busy", tx_busy, 0);
    chk("rst tx_done", tx_done, 0);
    repeat (2) step();
    uc_reset = 1'b1;
    step();
    // three-byte host block, then drain
    send_block(ADDR, 3, 8'h11, 8'h11);
    chk("rx3 level", rx_level, 3);
    step();
    chk("rx3 done pulses", rx_done_n, 1);
    rx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rx3 data", rx_data, 8'h11 * (i + 1));
      step();
    end
    rx_ready = 1'b0;
    chk("rx3 drained", rx_level, 0);
    // block for another address and an empty block
    send_block(ADDR + 3'd1, 2, 8'h55, 8'h01);
    step();
    chk("other addr level", rx_level, 0);
    chk("other addr done", rx_done_n, 1);
    send_block(ADDR, 0, 8'h00, 8'h00);
    step();
    chk("len0 done", rx_done_n, 2);
    // TX block of four bytes
    for (int i = 0; i < 4; i++) begin
      tx_data = 8'hA0 + 8'(i);
      tx_valid = 1'b1;
      step();
    end
    tx_valid = 1'b0;
    chk("tx4 level", tx_level, 4);
    tx_start = 1'b1;
    tx_len = 8'd4;
    step();
    tx_start = 1'b0;
    hdr = {ADDR, 1'b1, 8'd4, 18'd0};
    chk("tx4 busy", tx_busy, 1);
    for (int h = 0; h < HOLD; h++) begin
      if (h > 0) step();
      chk("tx4 header", uc_out, hdr);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      chk("tx4 byte", uc_out, hdr | 30'h100 | 30'(8'hA0 + 8'(i)));
      uc_in[UC_READY] = 1'b1;
      m_tx_pop = 1'b1;
      step();
      uc_in[UC_READY] = 1'b0;
      m_tx_pop = 1'b0;
      chk("tx4 hold", uc_out, hdr | 30'h100 | 30'(8'hA0 + 8'(i)));
      step();
    end
    chk("tx4 end uc_out", uc_out, 0);
    chk("tx4 done", tx_done, 1);
    step();
    chk("tx4 idle", tx_busy, 0);
    chk("tx4 done once", tx_done_n, 1);
    // rejected starts
    for (int i = 0; i < 2; i++) begin
      tx_data = 8'hB0 + 8'(i);
      tx_valid = 1'b1;
      step();
    end
    tx_valid = 1'b0;
    tx_start = 1'b1;
    tx_len = 8'd5;
    step();
    tx_start = 1'b0;
    chk("rej len5 pulse", tx_reject, 1);
    chk("rej len5 busy", tx_busy, 0);
    step();
    chk("rej pulse width", tx_reject, 0);
    tx_start = 1'b1;
    tx_len = 8'd0;
    step();
    tx_start = 1'b0;
    chk("rej len0 pulse", tx_reject, 1);
    step();
`ifdef EPT_ERR_CNT_EN
    chk("tx_reject_cnt", tx_reject_cnt, 2);
`endif
    // RX overflow: six bytes into a four-entry FIFO
    send_block(ADDR, 6, 8'hC0, 8'h01);
    chk("ovf level", rx_level, 4);
    chk("ovf flag", rx_overflow, 1);
`ifdef EPT_ERR_CNT_EN
    chk("rx_drop_cnt", rx_drop_cnt, 2);
`endif
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf data", rx_data, 8'hC0 + i);
      step();
    end
    rx_ready = 1'b0;
    chk("ovf sticky", rx_overflow, 1);
    chk("ovf done pulses", rx_done_n, 3);
    // reset in the middle of a three-byte TX block
    tx_data = 8'hB2;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    tx_start = 1'b1;
    tx_len = 8'd3;
    step();
    tx_len = 8'd0;
    step();
    tx_start = 1'b0;
    chk("start while busy", tx_reject, 0);
    hdr = {ADDR, 1'b1, 8'd3, 18'd0};
    step();
    chk("rst-tx byte0", uc_out, hdr | 30'h1B0);
    uc_in[UC_READY] = 1'b1;
    m_tx_pop = 1'b1;
    step();
    uc_in[UC_READY] = 1'b0;
    m_tx_pop = 1'b0;
    step();
    chk("rst-tx byte1", uc_out, hdr | 30'h1B1);
    uc_reset = 1'b0;
    #1;
    chk("rst-tx uc_out", uc_out, 0);
    chk("rst-tx level", tx_level, 0);
    chk("rst-tx busy", tx_busy, 0);
    chk("rst-tx ovf", rx_overflow, 0);
    repeat (2) step();
    uc_reset = 1'b1;
    repeat (3) step();
    chk("rst-tx no done", tx_done_n, 1);
    chk("rst-tx uc_out idle", uc_out, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
